// File: rtl/dpsystem_ctrl.sv
// -----------------------------------------------------------------------------
// dpsystem_ctrl
// Cycle scheduler and result-readout controller for the data processing
// system datapath.
//  * Issues a one-clock CycleStart pulse every PERIOD clocks while Enable=1.
//  * Double-buffers the host window configuration. A write goes into pending
//    registers, and those are copied to WindowDelay/WindowSizePow only on the
//    clock before CycleStart.
//  * Drains the result FIFO into a valid/ready stream (one record per
//    handshake) and counts cycles that started while the FIFO was full.
//
// Optional build macro: CYCLE_SYNC_IN_EN
//  When it is defined, an ExtSync input is added. ExtSync is synchronised with
//  two flops, and its rising edge replaces the internal period counter.
//  PERIOD/PW are then unused.
//
// Ports
//  Clock, nReset          clock, asynchronous active-low reset
//  Enable                 1 = generate processing cycles
//  CfgWrite/CfgDelay/CfgSizePow  host configuration write strobe + values
//  CfgErr                 one-clock pulse: last CfgWrite rejected (zero field)
//  CycleStart             one-clock cycle-start pulse to the datapath
//  WindowDelay/WindowSizePow     active window configuration
//  ExtSync                external cycle sync (CYCLE_SYNC_IN_EN only)
//  FifoState_empty/full   result FIFO flags
//  ReadData/ReadEna       FIFO read port (data valid the clock after ReadEna)
//  OutData/OutValid/OutReady     result record stream
//  OverrunCnt             saturating count of cycles started with FIFO full
// -----------------------------------------------------------------------------
module dpsystem_ctrl #(
    parameter int n      = 8,
    parameter int m      = 10,
    parameter int j      = 5,
    parameter int k      = 12,
    parameter int PERIOD = 100000,
    parameter int PW     = 17
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               Enable,
    input  logic               CfgWrite,
    input  logic [m-1:0]       CfgDelay,
    input  logic [j-1:0]       CfgSizePow,
    output logic               CfgErr,
    output logic               CycleStart,
    output logic [m-1:0]       WindowDelay,
    output logic [j-1:0]       WindowSizePow,
`ifdef CYCLE_SYNC_IN_EN
    input  logic               ExtSync,
`endif
    input  logic               FifoState_empty,
    input  logic               FifoState_full,
    input  logic [m+2*n+k-1:0] ReadData,
    output logic               ReadEna,
    output logic [m+2*n+k-1:0] OutData,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [7:0]         OverrunCnt
);

    localparam logic [m-1:0] DEF_DELAY = m'(10);
    localparam logic [j-1:0] DEF_SIZE  = j'(10);

    // apply_tick: the clock on which pending config becomes active.
    // start_tick: the clock on which CycleStart is registered high, which is
    //             always the clock after apply_tick.
    logic apply_tick;
    logic start_tick;

`ifdef CYCLE_SYNC_IN_EN
    // sync_q[1:0] is the two-flop synchroniser; sync_q[2] holds the previous
    // synchronised value so that a rising edge can be detected.
    logic [2:0] sync_q;
    logic       start_pend_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q       <= '0;
            start_pend_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], ExtSync};
            start_pend_q <= apply_tick;
        end
    end

    assign apply_tick = Enable && sync_q[1] && !sync_q[2];
    assign start_tick = Enable && start_pend_q;
`else
    localparam logic [PW-1:0] CNT_RELOAD = PW'(PERIOD - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (!Enable || (cnt_q == '0)) begin
            cnt_d = CNT_RELOAD;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= CNT_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign apply_tick = Enable && (cnt_q == PW'(1));
    assign start_tick = Enable && (cnt_q == '0);
`endif

    // ---------------------------------------------------------------------
    // Cycle start, configuration double-buffer, overrun counter
    // ---------------------------------------------------------------------
    logic         cycle_start_q;
    logic         cfg_err_q;
    logic         pend_q;
    logic [m-1:0] pend_delay_q;
    logic [j-1:0] pend_size_q;
    logic [m-1:0] win_delay_q;
    logic [j-1:0] win_size_q;
    logic [7:0]   ovr_q;
    logic         cfg_valid;

    // A zero delay or zero window size would stall the datapath, so such a
    // write is rejected.
    assign cfg_valid = CfgWrite && (CfgDelay != '0) && (CfgSizePow != '0);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cycle_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_delay_q  <= '0;
            pend_size_q   <= '0;
            win_delay_q   <= DEF_DELAY;
            win_size_q    <= DEF_SIZE;
            ovr_q         <= '0;
        end else begin
            cycle_start_q <= start_tick;
            cfg_err_q     <= CfgWrite && !cfg_valid;

            if (apply_tick && pend_q) begin
                win_delay_q <= pend_delay_q;
                win_size_q  <= pend_size_q;
            end

            // A write that lands on the apply clock stays pending for the
            // next cycle. The value applied above is the older pending value.
            if (cfg_valid) begin
                pend_delay_q <= CfgDelay;
                pend_size_q  <= CfgSizePow;
                pend_q       <= 1'b1;
            end else if (apply_tick) begin
                pend_q       <= 1'b0;
            end

            if (cycle_start_q && FifoState_full && (ovr_q != 8'hFF)) begin
                ovr_q <= ovr_q + 8'd1;
            end
        end
    end

    assign CycleStart    = cycle_start_q;
    assign CfgErr        = cfg_err_q;
    assign WindowDelay   = win_delay_q;
    assign WindowSizePow = win_size_q;
    assign OverrunCnt    = ovr_q;

    // ---------------------------------------------------------------------
    // Readout FSM: one FIFO read per record, hold the record until accepted
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_READ, R_CAP, R_HOLD} rd_state_t;

    rd_state_t            rd_state_q;
    logic                 read_ena_q;
    logic                 out_valid_q;
    logic [m+2*n+k-1:0]   out_data_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rd_state_q  <= R_IDLE;
            read_ena_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (!FifoState_empty) begin
                        rd_state_q <= R_READ;
                        read_ena_q <= 1'b1;
                    end
                end
                R_READ: begin
                    read_ena_q <= 1'b0;
                    rd_state_q <= R_CAP;
                end
                R_CAP: begin
                    // ReadData is valid on the clock after ReadEna.
                    out_data_q  <= ReadData;
                    out_valid_q <= 1'b1;
                    rd_state_q  <= R_HOLD;
                end
                R_HOLD: begin
                    if (OutReady) begin
                        out_valid_q <= 1'b0;
                        rd_state_q  <= R_IDLE;
                    end
                end
                default: begin
                    read_ena_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    rd_state_q  <= R_IDLE;
                end
            endcase
        end
    end

    assign ReadEna  = read_ena_q;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;

endmodule

// File: tb/tb_dpsystem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpsystem_ctrl
// Self-checking bench for dpsystem_ctrl, built with PERIOD=20.
// Expected timing comes from a phase model: the number of clocks since Enable
// went high. CycleStart is expected on every multiple of PERIOD, and the
// configuration is applied one clock earlier. The result FIFO is modelled as
// an array with a scoreboard queue of the records that were pushed.
// -----------------------------------------------------------------------------
module tb_dpsystem_ctrl;

    localparam int N  = 8;
    localparam int M  = 10;
    localparam int J  = 5;
    localparam int K  = 12;
    localparam int P  = 20;
    localparam int PWID = 5;
    localparam int W  = M + 2*N + K;

    logic          Clock = 1'b0;
    logic          nReset = 1'b1;
    logic          Enable = 1'b0;
    logic          CfgWrite = 1'b0;
    logic [M-1:0]  CfgDelay = '0;
    logic [J-1:0]  CfgSizePow = '0;
    logic          CfgErr;
    logic          CycleStart;
    logic [M-1:0]  WindowDelay;
    logic [J-1:0]  WindowSizePow;
    logic          FifoState_empty;
    logic          FifoState_full = 1'b0;
    logic [W-1:0]  ReadData = '0;
    logic          ReadEna;
    logic [W-1:0]  OutData;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [7:0]    OverrunCnt;

    int tests_run = 0;
    int tests_failed = 0;

    dpsystem_ctrl #(
        .n(N), .m(M), .j(J), .k(K), .PERIOD(P), .PW(PWID)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .Enable(Enable),
        .CfgWrite(CfgWrite),
        .CfgDelay(CfgDelay),
        .CfgSizePow(CfgSizePow),
        .CfgErr(CfgErr),
        .CycleStart(CycleStart),
        .WindowDelay(WindowDelay),
        .WindowSizePow(WindowSizePow),
        .FifoState_empty(FifoState_empty),
        .FifoState_full(FifoState_full),
        .ReadData(ReadData),
        .ReadEna(ReadEna),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OverrunCnt(OverrunCnt)
    );

    always #5 Clock = ~Clock;

    // ---------------- FIFO model + scoreboard ----------------
    logic [W-1:0] fifo_mem [256];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           re_count = 0;
    int           re_bad = 0;
    logic [W-1:0] sb [$];

    assign FifoState_empty = (wr_ptr == rd_ptr);

    always @(posedge Clock) begin
        if (ReadEna) begin
            ReadData <= fifo_mem[rd_ptr % 256];
            rd_ptr   <= rd_ptr + 1;
            re_count <= re_count + 1;
            if (FifoState_empty) re_bad <= re_bad + 1;
        end
    end

    task automatic push_record(output logic [W-1:0] d);
        d = W'({$urandom(), $urandom()});
        fifo_mem[wr_ptr % 256] = d;
        wr_ptr = wr_ptr + 1;
        sb.push_back(d);
    endtask

    // ---------------- cycle / config / overrun model ----------------
    int           phase;
    bit           m_cs;
    bit           m_pend;
    bit           m_err;
    logic [M-1:0] m_pd, m_ad;
    logic [J-1:0] m_ps, m_as;
    int           m_ovr;

    task automatic model_reset();
        phase = 0; m_cs = 0; m_pend = 0; m_err = 0;
        m_pd = '0; m_ps = '0; m_ad = M'(10); m_as = J'(10); m_ovr = 0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // and return at the following falling edge, where outputs are compared.
    task automatic tick();
        bit prev_cs;
        bit en;
        prev_cs = m_cs;
        @(posedge Clock);
        en = Enable;
        if (prev_cs && FifoState_full) m_ovr = (m_ovr >= 255) ? 255 : m_ovr + 1;
        if (en) phase++; else phase = 0;
        m_cs = en && (phase > 0) && (phase % P == 0);
        if (en && (phase % P == P - 1) && m_pend) begin
            m_ad = m_pd; m_as = m_ps; m_pend = 0;
        end
        m_err = CfgWrite && (CfgDelay == '0 || CfgSizePow == '0);
        if (CfgWrite && !m_err) begin
            m_pd = CfgDelay; m_ps = CfgSizePow; m_pend = 1;
        end
        @(negedge Clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 nReset = 1'b0;
        Enable = 1'b1;
        repeat (3) @(negedge Clock);
        tests_run += 8;
        if (CycleStart !== 1'b0) begin tests_failed++; $display("FAIL reset_cyclestart got=%0b exp=0", CycleStart); end
        if (ReadEna !== 1'b0) begin tests_failed++; $display("FAIL reset_readena got=%0b exp=0", ReadEna); end
        if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid got=%0b exp=0", OutValid); end
        if (CfgErr !== 1'b0) begin tests_failed++; $display("FAIL reset_cfgerr got=%0b exp=0", CfgErr); end
        if (OutData !== '0) begin tests_failed++; $display("FAIL reset_outdata got=%h exp=0", OutData); end
        if (OverrunCnt !== 8'd0) begin tests_failed++; $display("FAIL reset_overrun got=%0d exp=0", OverrunCnt); end
        if (WindowDelay !== M'(10)) begin tests_failed++; $display("FAIL reset_delay got=%0d exp=10", WindowDelay); end
        if (WindowSizePow !== J'(10)) begin tests_failed++; $display("FAIL reset_size got=%0d exp=10", WindowSizePow); end
        nReset = 1'b1;
        model_reset();
    endtask

    task automatic test_cycle_timing();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3*P + 2; i++) begin
            tick();
            if (CycleStart === 1'b1) pulses++;
            tests_run++;
            if (CycleStart !== m_cs || WindowDelay !== m_ad || WindowSizePow !== m_as) begin
                tests_failed++;
                $display("FAIL cycle_timing clk=%0d got cs=%0b win=%0d/%0d exp cs=%0b win=%0d/%0d",
                         phase, CycleStart, WindowDelay, WindowSizePow, m_cs, m_ad, m_as);
            end
        end
        tests_run++;
        if (pulses != 3) begin tests_failed++; $display("FAIL cycle_count got=%0d exp=3", pulses); end
    endtask

    task automatic test_cfg_apply();
        int target;
        int guard;
        bit seen_cs;
        target = 5 + int'($urandom_range(0, 8));
        guard = 0;
        while ((phase % P) != target && guard < 3*P) begin tick(); guard++; end
        CfgWrite = 1'b1; CfgDelay = M'(5); CfgSizePow = J'(8);
        tick();
        CfgWrite = 1'b0;
        seen_cs = 0;
        for (int i = 0; i < 2*P && !seen_cs; i++) begin
            tests_run++;
            if (WindowDelay !== m_ad || WindowSizePow !== m_as || CycleStart !== m_cs) begin
                tests_failed++;
                $display("FAIL cfg_apply got cs=%0b win=%0d/%0d exp cs=%0b win=%0d/%0d",
                         CycleStart, WindowDelay, WindowSizePow, m_cs, m_ad, m_as);
            end
            if (CycleStart === 1'b1) begin
                seen_cs = 1;
                tests_run++;
                if (WindowDelay !== M'(5) || WindowSizePow !== J'(8)) begin
                    tests_failed++;
                    $display("FAIL cfg_at_start got=%0d/%0d exp=5/8", WindowDelay, WindowSizePow);
                end
            end else begin
                tick();
            end
        end
        tests_run++;
        if (!seen_cs) begin tests_failed++; $display("FAIL cfg_apply_timeout got=no CycleStart exp=CycleStart"); end

        // Random writes, plus one landing on every apply clock.
        for (int i = 0; i < 8*P; i++) begin
            if ((phase % P) == P - 2 || $urandom_range(0, 5) == 0) begin
                CfgWrite = 1'b1;
                CfgDelay = M'($urandom_range(1, 1023));
                CfgSizePow = J'($urandom_range(1, 31));
            end
            tick();
            CfgWrite = 1'b0;
            tests_run++;
            if (WindowDelay !== m_ad || WindowSizePow !== m_as || CycleStart !== m_cs || CfgErr !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_random got cs=%0b err=%0b win=%0d/%0d exp cs=%0b err=0 win=%0d/%0d",
                         CycleStart, CfgErr, WindowDelay, WindowSizePow, m_cs, m_ad, m_as);
            end
        end
    endtask

    task automatic test_cfg_reject();
        logic [M-1:0] d0;
        logic [J-1:0] s0;
        repeat (2*P) tick();  // let any pending config apply first
        d0 = m_ad; s0 = m_as;
        for (int r = 0; r < 2; r++) begin
            CfgWrite = 1'b1;
            CfgDelay = (r == 0) ? M'(0) : M'(7);
            CfgSizePow = (r == 0) ? J'(8) : J'(0);
            tick();
            CfgWrite = 1'b0;
            tests_run++;
            if (CfgErr !== 1'b1 || m_err != 1'b1) begin
                tests_failed++; $display("FAIL cfg_err_pulse case=%0d got=%0b exp=1", r, CfgErr);
            end
            tick();
            tests_run++;
            if (CfgErr !== 1'b0) begin tests_failed++; $display("FAIL cfg_err_width case=%0d got=%0b exp=0", r, CfgErr); end
        end
        for (int i = 0; i < 3*P; i++) begin
            tick();
            tests_run++;
            if (WindowDelay !== d0 || WindowSizePow !== s0 || CycleStart !== m_cs) begin
                tests_failed++;
                $display("FAIL cfg_reject_hold got win=%0d/%0d cs=%0b exp win=%0d/%0d cs=%0b",
                         WindowDelay, WindowSizePow, CycleStart, d0, s0, m_cs);
            end
        end
    endtask

    task automatic test_enable();
        int first;
        Enable = 1'b0;
        for (int i = 0; i < 2*P + 3; i++) begin
            tick();
            tests_run++;
            if (CycleStart !== 1'b0) begin tests_failed++; $display("FAIL disabled_cs got=%0b exp=0", CycleStart); end
        end
        Enable = 1'b1;
        first = 0;
        for (int i = 1; i <= 3*P && first == 0; i++) begin
            tick();
            if (CycleStart === 1'b1) first = i;
        end
        tests_run++;
        if (first != P) begin tests_failed++; $display("FAIL enable_first_cs got=%0d exp=%0d", first, P); end
    endtask

    task automatic test_readout();
        logic [W-1:0] d;
        int lat;
        int re0;
        int budget;
        OutReady = 1'b1;
        re0 = re_count;
        for (int i = 0; i < 3; i++) push_record(d);
        lat = 0;
        while (OutValid !== 1'b1 && lat < 20) begin tick(); lat++; end
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL readout_latency got=%0d exp=3", lat); end
        budget = 0;
        while (sb.size() > 0 && budget < 60) begin
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                tests_run++;
                if (OutData !== sb[0]) begin tests_failed++; $display("FAIL readout_data got=%h exp=%h", OutData, sb[0]); end
                void'(sb.pop_front());
            end
            tick();
            budget++;
        end
        tick();
        tests_run += 2;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL readout_drain got=%0d left exp=0", sb.size()); end
        if (re_count - re0 != 3) begin tests_failed++; $display("FAIL readout_readena got=%0d exp=3", re_count - re0); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        int guard;
        int re0;
        OutReady = 1'b0;
        push_record(d0);
        guard = 0;
        while (OutValid !== 1'b1 && guard < 20) begin tick(); guard++; end
        push_record(d1);
        re0 = re_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (OutValid !== 1'b1 || OutData !== d0) begin
                tests_failed++; $display("FAIL hold_stable got v=%0b d=%h exp v=1 d=%h", OutValid, OutData, d0);
            end
        end
        tests_run++;
        if (re_count != re0) begin tests_failed++; $display("FAIL hold_no_read got=%0d exp=0", re_count - re0); end
        OutReady = 1'b1;
        tests_run++;
        if (OutData !== sb[0]) begin tests_failed++; $display("FAIL hold_accept_data got=%h exp=%h", OutData, sb[0]); end
        void'(sb.pop_front());
        tick();
        tests_run++;
        if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL hold_accept_valid got=%0b exp=0", OutValid); end
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            if (OutValid === 1'b1) begin
                tests_run++;
                if (OutData !== sb[0]) begin tests_failed++; $display("FAIL hold_next_data got=%h exp=%h", OutData, sb[0]); end
                void'(sb.pop_front());
            end
            tick();
            guard++;
        end
        tick();
    endtask

    task automatic test_random_stream();
        logic [W-1:0] d;
        int guard;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0 && sb.size() < 8) push_record(d);
            OutReady = ($urandom_range(0, 2) != 0);
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                tests_run++;
                if (OutData !== sb[0]) begin tests_failed++; $display("FAIL stream_data got=%h exp=%h", OutData, sb[0]); end
                void'(sb.pop_front());
            end
            tick();
        end
        OutReady = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            if (OutValid === 1'b1) begin
                tests_run++;
                if (OutData !== sb[0]) begin tests_failed++; $display("FAIL stream_data got=%h exp=%h", OutData, sb[0]); end
                void'(sb.pop_front());
            end
            tick();
            guard++;
        end
        tick();
        tests_run += 2;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL stream_drain got=%0d left exp=0", sb.size()); end
        if (re_bad != 0) begin tests_failed++; $display("FAIL read_when_empty got=%0d exp=0", re_bad); end
    endtask

    task automatic test_overrun_and_reset();
        int guard;
        FifoState_full = 1'b1;
        for (int i = 0; i < 300*P + 5; i++) begin
            tick();
            if (i % P == 7) begin
                tests_run++;
                if (OverrunCnt !== 8'(m_ovr)) begin
                    tests_failed++; $display("FAIL overrun_count got=%0d exp=%0d", OverrunCnt, m_ovr);
                end
            end
        end
        tests_run++;
        if (OverrunCnt !== 8'd255) begin tests_failed++; $display("FAIL overrun_saturate got=%0d exp=255", OverrunCnt); end
        FifoState_full = 1'b0;
        // Leave a valid config pending, then reset before it can apply.
        guard = 0;
        while ((phase % P) != 3 && guard < 2*P) begin tick(); guard++; end
        CfgWrite = 1'b1; CfgDelay = M'(3); CfgSizePow = J'(3);
        tick();
        CfgWrite = 1'b0;
        tick();
        #2 nReset = 1'b0;
        #1;
        tests_run += 4;
        if (OverrunCnt !== 8'd0) begin tests_failed++; $display("FAIL midreset_overrun got=%0d exp=0", OverrunCnt); end
        if (WindowDelay !== M'(10)) begin tests_failed++; $display("FAIL midreset_delay got=%0d exp=10", WindowDelay); end
        if (WindowSizePow !== J'(10)) begin tests_failed++; $display("FAIL midreset_size got=%0d exp=10", WindowSizePow); end
        if (CycleStart !== 1'b0) begin tests_failed++; $display("FAIL midreset_cs got=%0b exp=0", CycleStart); end
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        model_reset();
        for (int i = 0; i < 2*P + 1; i++) begin
            tick();
            tests_run++;
            if (WindowDelay !== M'(10) || WindowSizePow !== J'(10) || CycleStart !== m_cs) begin
                tests_failed++;
                $display("FAIL pending_discarded got win=%0d/%0d cs=%0b exp win=10/10 cs=%0b",
                         WindowDelay, WindowSizePow, CycleStart, m_cs);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cycle_timing();
        test_cfg_apply();
        test_cfg_reject();
        test_enable();
        test_readout();
        test_backpressure();
        test_random_stream();
        test_overrun_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dpsystem_ctrl.md
Name: dpsystem_ctrl

Overview:
Cycle scheduler and result-readout controller for the data processing system datapath.
- Generates the periodic CycleStart pulse.
- Double-buffers host window configuration (WindowDelay, WindowSizePow) and applies it only at cycle boundaries.
- Drains the result FIFO into a valid/ready output stream and counts FIFO overruns.
- Sits between host logic and the datapath top; all signals are in one clock domain.

Parameters:
n, 8, sample width
m, 10, WindowDelay / MaxTime width
j, 5, WindowSizePow width
k, 12, CycleNumber width
PERIOD, 100000, clocks per processing cycle (1 kHz at 100 MHz); must be ≥ 4
PW, 17, period counter width; 2^PW > PERIOD

Ports:
Clock  in  1  system clock, 100 MHz
nReset  in  1  asynchronous reset, active-low
Enable  in  1  1 = generate cycles
CfgWrite  in  1  one-clock strobe: load CfgDelay/CfgSizePow into the pending registers
CfgDelay  in  m  requested window delay
CfgSizePow  in  j  requested window size
CfgErr  out  1  one-clock pulse: CfgWrite was rejected
CycleStart  out  1  one-clock cycle-start pulse to the datapath
WindowDelay  out  m  active delay to the datapath
WindowSizePow  out  j  active window size to the datapath
FifoState_empty  in  1  FIFO empty flag
FifoState_full  in  1  FIFO full flag
ReadData  in  m+2n+k  FIFO read data, valid the clock after ReadEna
ReadEna  out  1  FIFO read strobe
OutData  out  m+2n+k  captured result record
OutValid  out  1  OutData valid
OutReady  in  1  downstream accept
OverrunCnt  out  8  saturating count of cycles started while the FIFO was full

Behaviour:
- Reset values:
  - CycleStart, ReadEna, OutValid, CfgErr = 0
  - OutData = 0, OverrunCnt = 0
  - WindowDelay = 10, WindowSizePow = 10 (match the datapath reset defaults)
  - pending flag = 0; period counter = PERIOD-1
- Period counter:
  - While Enable=1, decrements each clock.
  - At count 0: CycleStart=1 for exactly one clock, and the counter reloads PERIOD-1.
  - Result: CycleStart period is exactly PERIOD clocks.
  - Enable=0: counter is forced to PERIOD-1 and no CycleStart is issued. After Enable rises, the first CycleStart comes PERIOD clocks later.
- Configuration:
  - CfgWrite with CfgDelay==0 or CfgSizePow==0 is rejected: pending registers are unchanged and CfgErr pulses on the next clock.
  - Otherwise the pending registers and pending flag are loaded. A later CfgWrite before apply overwrites them (last write wins).
  - Apply happens on the edge where the period counter == 1. Pending values are copied to WindowDelay/WindowSizePow and the flag is cleared. New values are therefore stable during the CycleStart clock.
  - WindowDelay/WindowSizePow never change at any other time.
  - CfgWrite on the apply clock: the new write is held pending for the next cycle; the old pending value is applied.
- Overrun: if FifoState_full=1 in a CycleStart clock, OverrunCnt increments, saturating at 255.
- Readout FSM:
  - R_IDLE: if FifoState_empty=0, go to R_READ.
  - R_READ: ReadEna=1 for one clock, then R_CAP.
  - R_CAP: OutData <= ReadData, then R_HOLD.
  - R_HOLD: OutValid=1. OutData stays stable until OutValid & OutReady; on that clock go to R_IDLE.
  - At most one ReadEna per record. ReadEna is never asserted while FifoState_empty=1.
  - Record latency from non-empty to OutValid: 3 clocks. Minimum throughput: one record per 4 clocks.
- Readout and cycle generation are independent. Enable=0 does not stop draining.
- nReset assertion mid-operation returns all state to reset values immediately. A pending config is discarded.

Optional Feature:
CYCLE_SYNC_IN_EN
- Defined:
  - Adds input ExtSync (1 bit, asynchronous), synchronised with 2 flops.
  - A rising edge detected on the synchronised signal replaces counter 0. The config apply happens at that clock; CycleStart is asserted on the next clock.
  - Latency from ExtSync rise to CycleStart: 4 clocks. Enable still gates generation.
  - PERIOD is unused.
- Undefined: no ExtSync port; internal period counter only.

Test Plan:
- PERIOD=20, Enable=1 from reset -> CycleStart pulses 1 clock wide, every 20 clocks; WindowDelay=10, WindowSizePow=10.
- CfgWrite Delay=5 Size=8 mid-cycle -> outputs stay 10/10 until the edge before the next CycleStart, then 5/8 during that CycleStart clock.
- CfgWrite Delay=0 Size=8 -> CfgErr one pulse; outputs unchanged across the next 3 cycles.
- FIFO model holding 3 records, OutReady=1 -> 3 single ReadEna pulses; OutData matches in order; first OutValid 3 clocks after empty falls.
- OutReady=0 for 10 clocks with a record held -> OutValid high and OutData stable; no further ReadEna; record accepted on the OutReady rise.
- FifoState_full=1 across 300 CycleStarts -> OverrunCnt saturates at 255; nReset mid-run -> OverrunCnt=0 and WindowDelay=10.
